// File: rtl/spmv_pkg.sv
// Shared types for the SpMV lane-select path: skid-buffer occupancy states and
// a ceil(log2) helper used for elaboration-time width checks.
package spmv_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } skid_state_e;

   function automatic int unsigned spmv_clog2(input int unsigned n);
      int unsigned r;
      int unsigned v;
      r = 0;
      v = 1;
      while (v < n) begin
         v = v << 1;
         r = r + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/bin_to_onehot_dec.sv
// Combinational binary-to-one-hot decoder; err flags indices with no matching
// output bit (the vector is then all-zero).
module bin_to_onehot_dec
   import spmv_pkg::*;
#(
   parameter int ONEHOT_WIDTH = 50,
   parameter int BIN_WIDTH    = 6
) (
   input  logic [BIN_WIDTH-1:0]    bin,
   output logic [ONEHOT_WIDTH-1:0] onehot,
   output logic                    err
);

   if (BIN_WIDTH < int'(spmv_clog2(ONEHOT_WIDTH))) begin : g_bad_width
      $error("bin_to_onehot_dec: BIN_WIDTH too narrow for ONEHOT_WIDTH");
   end

   for (genvar k = 0; k < ONEHOT_WIDTH; k++) begin : g_bit
      assign onehot[k] = (bin == BIN_WIDTH'(k));
   end

   // No bit matched exactly when the index is out of range.
   assign err = ~|onehot;

endmodule

// File: rtl/bin_to_onehot_stream.sv
// Streaming index-to-one-hot decoder with a 2-entry skid buffer (output
// register + skid register), registered in_ready and a saturating error count.
module bin_to_onehot_stream
   import spmv_pkg::*;
#(
   parameter int ONEHOT_WIDTH = 50,
   parameter int BIN_WIDTH    = 6,
   parameter int CNT_WIDTH    = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [BIN_WIDTH-1:0]    in_bin,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [ONEHOT_WIDTH-1:0] out_onehot,
   output logic [BIN_WIDTH-1:0]    out_bin,
   output logic                    out_err,
   output logic [CNT_WIDTH-1:0]    err_count,
   input  logic                    clr_err
);

   logic [ONEHOT_WIDTH-1:0] w_onehot;
   logic                    w_err;
   logic                    w_accept;
   logic                    w_pop;
   logic                    w_err_accept;

   skid_state_e             r_state;
   logic                    r_in_ready;
   logic                    r_out_valid;
   logic [ONEHOT_WIDTH-1:0] r_out_onehot;
   logic [BIN_WIDTH-1:0]    r_out_bin;
   logic                    r_out_err;
   logic [ONEHOT_WIDTH-1:0] r_skid_onehot;
   logic [BIN_WIDTH-1:0]    r_skid_bin;
   logic                    r_skid_err;
   logic [CNT_WIDTH-1:0]    r_err_count;

   bin_to_onehot_dec #(
      .ONEHOT_WIDTH (ONEHOT_WIDTH),
      .BIN_WIDTH    (BIN_WIDTH)
   ) u_dec (
      .bin    (in_bin),
      .onehot (w_onehot),
      .err    (w_err)
   );

   assign w_accept     = in_valid & r_in_ready;
   assign w_pop        = r_out_valid & out_ready;
   assign w_err_accept = w_accept & w_err;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= EMPTY;
         r_in_ready    <= 1'b0;
         r_out_valid   <= 1'b0;
         r_out_onehot  <= '0;
         r_out_bin     <= '0;
         r_out_err     <= 1'b0;
         r_skid_onehot <= '0;
         r_skid_bin    <= '0;
         r_skid_err    <= 1'b0;
      end else begin
         case (r_state)
            EMPTY: begin
               // in_ready is 0 only on the first edge after reset release.
               r_in_ready <= 1'b1;
               if (w_accept) begin
                  r_out_onehot <= w_onehot;
                  r_out_bin    <= in_bin;
                  r_out_err    <= w_err;
                  r_out_valid  <= 1'b1;
                  r_state      <= ONE;
               end
            end
            ONE: begin
               if (w_accept && w_pop) begin
                  r_out_onehot <= w_onehot;
                  r_out_bin    <= in_bin;
                  r_out_err    <= w_err;
               end else if (w_accept) begin
                  r_skid_onehot <= w_onehot;
                  r_skid_bin    <= in_bin;
                  r_skid_err    <= w_err;
                  r_in_ready    <= 1'b0;
                  r_state       <= FULL;
               end else if (w_pop) begin
                  r_out_valid <= 1'b0;
                  r_state     <= EMPTY;
               end
            end
            FULL: begin
               if (w_pop) begin
                  r_out_onehot <= r_skid_onehot;
                  r_out_bin    <= r_skid_bin;
                  r_out_err    <= r_skid_err;
                  r_in_ready   <= 1'b1;
                  r_state      <= ONE;
               end
            end
            default: begin
               r_in_ready  <= 1'b0;
               r_out_valid <= 1'b0;
               r_state     <= EMPTY;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_err_count <= '0;
      end else if (clr_err) begin
         r_err_count <= w_err_accept ? CNT_WIDTH'(1) : '0;
      end else if (w_err_accept && (r_err_count != '1)) begin
         r_err_count <= r_err_count + CNT_WIDTH'(1);
      end
   end

   assign in_ready   = r_in_ready;
   assign out_valid  = r_out_valid;
   assign out_onehot = r_out_onehot;
   assign out_bin    = r_out_bin;
   assign out_err    = r_out_err;
   assign err_count  = r_err_count;

endmodule

// File: tb/tb_bin_to_onehot_stream.sv
// Bench for bin_to_onehot_stream: directed scenarios plus random traffic, all
// checked against a queue-based model of the two-deep buffer and error counter.
module tb_bin_to_onehot_stream;

   localparam int OW = 50;
   localparam int BW = 6;

   logic          clk;
   logic          rst_n;
   logic          in_valid;
   logic [BW-1:0] in_bin;
   logic          out_ready;
   logic          clr_err;

   logic          in_ready,   in_ready2;
   logic          out_valid,  out_valid2;
   logic [OW-1:0] out_onehot, out_onehot2;
   logic [BW-1:0] out_bin,    out_bin2;
   logic          out_err,    out_err2;
   logic [15:0]   err_count;
   logic [1:0]    err_count2;

   int n_checks;
   int n_pass;

   int q[$];
   bit m_ready;
   int m_cnt;
   int m_cnt2;

   bin_to_onehot_stream #(.ONEHOT_WIDTH(OW), .BIN_WIDTH(BW), .CNT_WIDTH(16)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_bin(in_bin), .out_valid(out_valid), .out_ready(out_ready),
      .out_onehot(out_onehot), .out_bin(out_bin), .out_err(out_err),
      .err_count(err_count), .clr_err(clr_err)
   );

   bin_to_onehot_stream #(.ONEHOT_WIDTH(OW), .BIN_WIDTH(BW), .CNT_WIDTH(2)) dut_sat (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
      .in_bin(in_bin), .out_valid(out_valid2), .out_ready(out_ready),
      .out_onehot(out_onehot2), .out_bin(out_bin2), .out_err(out_err2),
      .err_count(err_count2), .clr_err(clr_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic model_reset();
      q.delete();
      m_ready = 1'b0;
      m_cnt   = 0;
      m_cnt2  = 0;
   endtask

   // Check current outputs, drive one cycle of inputs, advance model over the edge.
   task automatic step(input bit v, input int b, input bit ordy, input bit clr);
      logic [OW-1:0] e;
      bit            acc;
      bit            aerr;
      check("in_ready",   64'(in_ready),   64'(m_ready));
      check("in_ready2",  64'(in_ready2),  64'(m_ready));
      check("out_valid",  64'(out_valid),  64'(q.size() > 0));
      check("out_valid2", 64'(out_valid2), 64'(q.size() > 0));
      if (q.size() > 0) begin
         e = '0;
         if (q[0] < OW) e[q[0]] = 1'b1;
         check("out_onehot",  64'(out_onehot),  64'(e));
         check("out_onehot2", 64'(out_onehot2), 64'(e));
         check("out_bin",     64'(out_bin),     64'(q[0]));
         check("out_err",     64'(out_err),     64'(q[0] >= OW));
         check("out_err2",    64'(out_err2),    64'(q[0] >= OW));
      end else if (!rst_n) begin
         check("rst_onehot", 64'(out_onehot), 64'(0));
         check("rst_bin",    64'(out_bin),    64'(0));
         check("rst_err",    64'(out_err),    64'(0));
      end
      check("err_count",  64'(err_count),  64'(m_cnt));
      check("err_count2", 64'(err_count2), 64'(m_cnt2));

      in_valid  = v;
      in_bin    = BW'(b);
      out_ready = ordy;
      clr_err   = clr;
      @(posedge clk);
      if (!rst_n) begin
         model_reset();
      end else begin
         acc  = v && m_ready;
         aerr = acc && (b >= OW);
         if (q.size() > 0 && ordy) void'(q.pop_front());
         if (acc) q.push_back(b);
         m_ready = (q.size() < 2);
         if (clr) begin
            m_cnt  = aerr ? 1 : 0;
            m_cnt2 = aerr ? 1 : 0;
         end else if (aerr) begin
            m_cnt  = (m_cnt  < 65535) ? m_cnt  + 1 : m_cnt;
            m_cnt2 = (m_cnt2 < 3)     ? m_cnt2 + 1 : m_cnt2;
         end
      end
      @(negedge clk);
   endtask

   initial begin
      bit pend_v;
      int pend_b;
      bit v;
      int b;
      bit pre_ready;

      n_checks  = 0;
      n_pass    = 0;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_bin    = '0;
      out_ready = 1'b0;
      clr_err   = 1'b0;
      model_reset();
      @(negedge clk);

      // Reset held with traffic present: nothing may be accepted.
      for (int i = 0; i < 3; i++) step(1, 3, 1, 0);
      rst_n = 1'b1;
      step(0, 0, 1, 0);
      step(0, 0, 1, 0);

      // Back-to-back stream including the top legal index.
      step(1, 0, 1, 0);
      step(1, 1, 1, 0);
      step(1, 49, 1, 0);
      step(0, 0, 1, 0);
      step(0, 0, 1, 0);

      // Backpressure: fill both entries, hold, then drain in order.
      step(1, 5, 0, 0);
      step(1, 7, 0, 0);
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      for (int i = 0; i < 3; i++) step(0, 0, 1, 0);

      // Error path and clear coinciding with an erroneous accept.
      step(1, 50, 1, 0);
      step(1, 63, 1, 0);
      step(1, 55, 1, 1);
      step(0, 0, 1, 0);
      step(0, 0, 1, 0);

      // Clear alone, then saturation of the 2-bit counter.
      step(0, 0, 1, 1);
      for (int i = 0; i < 5; i++) step(1, 50 + i, 1, 0);
      step(0, 0, 1, 0);
      step(0, 0, 1, 0);

      // Asynchronous reset while FULL discards both held entries.
      step(1, 3, 0, 0);
      step(1, 4, 0, 0);
      #1 rst_n = 1'b0;
      #1;
      check("async_out_valid", 64'(out_valid),  64'(0));
      check("async_in_ready",  64'(in_ready),   64'(0));
      check("async_onehot",    64'(out_onehot), 64'(0));
      #1 rst_n = 1'b1;
      model_reset();
      step(0, 0, 1, 0);
      step(1, 8, 1, 0);
      step(0, 0, 1, 0);
      step(0, 0, 1, 0);

      // Random traffic; a refused item is held until taken.
      pend_v = 1'b0;
      pend_b = 0;
      for (int i = 0; i < 400; i++) begin
         if (pend_v) begin
            v = 1'b1;
            b = pend_b;
         end else begin
            v = ($urandom_range(0, 9) < 7);
            b = int'($urandom_range(0, 63));
         end
         pre_ready = m_ready;
         step(v, b, ($urandom_range(0, 9) < 6), ($urandom_range(0, 19) == 0));
         pend_v = v && !pre_ready;
         pend_b = b;
      end
      for (int i = 0; i < 3; i++) step(0, 0, 1, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
